mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the execute stage; sits beside the ALU, takes the same two forwarded operands (A_in, B_in), and owns the architectural HI/LO registers for mult/multu/div/divu/mthi/mtlo/mfhi/mflo. A radix-2 datapath takes one bit per cycle. While an operation is in flight it holds `busy` high so hazard logic can stall any later HI/LO access. HI/LO feed the EX-stage result mux alongside ALU_out.

## Interface
- `XLEN`, 32 — operand width. Only 32 is supported.
- `clk`  in  1  — rising-edge clock.
- `rst_n`  in  1  — synchronous, active-low reset.
- `start`  in  1  — request an operation. Sampled only in IDLE.
- `md_op`  in  2  — operation: 00 mult, 01 multu, 10 div, 11 divu.
- `A_in`  in  32  — rs operand (multiplicand or dividend). Sampled with `start`.
- `B_in`  in  32  — rt operand (multiplier or divisor). Sampled with `start`.
- `hilo_we`  in  2  — bit1 writes A_in into HI (mthi); bit0 writes A_in into LO (mtlo).
- `flush`  in  1  — abort the in-flight operation; HI/LO are left unchanged.
- `busy`  out  1  — operation in flight.
- `done`  out  1  — one-cycle pulse when HI/LO have just been updated.
- `div_zero`  out  1  — one-cycle pulse, coincident with `done`, when the divisor was 0.
- `HI`  out  32  — HI register.
- `LO`  out  32  — LO register.

## Operation
- FSM states:
  - IDLE: `start`=1 → CALC. Operand magnitudes and sign flags are latched and the counter is cleared.
  - CALC: runs 32 iterations, count 0..31. At count 31 → FIX.
  - FIX: 64-bit sign correction; HI/LO are written; → IDLE. `done` is asserted the following cycle.
- Multiply: shift-add on |A|,|B| (or the raw values for multu). The 64-bit product goes to {HI,LO}. For mult, the product is negated if sign(A)^sign(B).
- Divide: restoring division on magnitudes.
  - LO = quotient, HI = remainder.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - -2^31 / -1 gives LO=0x8000_0000, HI=0 (truncated, no trap).
- Divide by zero: LO=0xFFFF_FFFF, HI=dividend (raw A_in), `div_zero` pulses. The full 34-cycle latency still applies.
- `start` while `busy`: ignored. The upstream stage must stall.
- `hilo_we`:
  - Honoured only when not busy.
  - Writes while busy are dropped.
  - The same-cycle `start`+`hilo_we` combination is illegal; `hilo_we` wins and `start` is dropped.
- `flush`:
  - In CALC or FIX: → IDLE next edge, `busy`=0, no `done`, HI/LO unchanged.
  - `flush` has priority over FIX's write.
  - `flush` in IDLE also blocks a same-cycle `start`.

## Timing
- Reset (`rst_n`=0 at an edge) gives: state IDLE, HI=LO=0, `busy`=0, `done`=0, `div_zero`=0.
- Reset overrides everything, including mid-operation.
- Let edge N be the edge at which `start` is accepted:
  - `busy` is 1 from after N through after N+33.
  - HI/LO take the result at edge N+34.
  - `busy`=0 and `done`=1 during the cycle after N+34.
- A new `start` is accepted at edge N+34 at the earliest (back-to-back). `done` of the previous operation and `busy` of the new one then overlap.
- An mthi/mtlo write is visible on HI/LO the cycle after its edge (one-cycle latency).
- `busy` and `done` are registered; no combinational path from inputs.

## Configuration
- `MD_DIV_EN` defined: div/divu supported as above.
- `MD_DIV_EN` undefined: the divider datapath is not built.
  - `start` with md_op[1]=1 is ignored: FSM stays in IDLE, `busy` stays 0, HI/LO unchanged.
  - `div_zero` is tied to 0.
  - Multiply timing is unchanged.

## Structure
- Package `md_pkg`:
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - FSM state enum (IDLE, CALC, FIX).
  - MD_ITER=32.
  - Divide-by-zero LO constant 32'hFFFF_FFFF.
- One sub-module, `md_sign_fix`: combinational. It takes a 64-bit magnitude result plus negate-hi/negate-lo controls and returns the corrected {HI,LO}. It is shared by both multiply and divide.

## Test plan
- multu A=0xFFFF_FFFF, B=0xFFFF_FFFF → after 34 cycles HI=0xFFFF_FFFE, LO=0x0000_0001, `done` pulses once, `busy` high for exactly 34 cycles.
- mult A=-3 (0xFFFF_FFFD), B=7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; back-to-back start at edge N+34 accepted.
- div A=-7, B=2 → LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); divu A=7, B=0 → LO=0xFFFF_FFFF, HI=7, `div_zero`=1 with `done`.
- mtlo A=0x1234 in IDLE → LO=0x1234 next cycle; mthi during `busy` → HI unchanged; `start` during `busy` → ignored, single `done`.
- `flush` at cycle 10 of CALC → `busy`=0 next cycle, no `done`, HI/LO keep their prior values; `rst_n`=0 mid-CALC → HI=LO=0, IDLE.
- Without `MD_DIV_EN`: div start → `busy` stays 0, HI/LO unchanged; mult still completes in 34 cycles.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared encodings and constants for the iterative multiply/divide unit.
package md_pkg;
    localparam int MD_ITER = 32;
    localparam logic [31:0] MD_DZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand/request and HI/LO result bundle between the EX stage and mul_div_unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      md_op;
    logic [XLEN-1:0] A_in;
    logic [XLEN-1:0] B_in;
    logic [1:0]      hilo_we;
    logic            flush;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (
        output start, md_op, A_in, B_in, hilo_we, flush,
        input  busy, done, div_zero, HI, LO
    );

    modport slave (
        input  start, md_op, A_in, B_in, hilo_we, flush,
        output busy, done, div_zero, HI, LO
    );
endinterface

// File: rtl/md_sign_fix.sv
// md_sign_fix: turns a {HI,LO} magnitude into the signed result; wide=1 negates all 64 bits
// as one value (multiply), wide=0 negates each half on its own (quotient / remainder).
module md_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] mag,
    input  logic              wide,
    input  logic              neg_hi,
    input  logic              neg_lo,
    output logic [2*XLEN-1:0] res
);
    always_comb begin
        res = mag;
        if (wide) begin
            if (neg_hi) res = -mag;
        end else begin
            if (neg_hi) res[2*XLEN-1:XLEN] = -mag[2*XLEN-1:XLEN];
            if (neg_lo) res[XLEN-1:0]      = -mag[XLEN-1:0];
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative mult/multu/div/divu owning HI/LO, one bit per cycle.
// Define MD_DIV_EN to build the restoring divider; without it div/divu requests are ignored.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst_n,
    mul_div_unit_if.slave bus
);
    md_op_e               op;
    md_state_e            state, state_nxt;
    logic [4:0]           cnt;
    logic                 is_div, is_sgn, div_ok, accept, fix_vld, dz_fix;
    logic signed [XLEN-1:0] a_s, b_s;
    logic                 neg_a, neg_b;
    logic [XLEN-1:0]      mag_a, mag_b, opnd_p0;
    logic [2*XLEN-1:0]    w_p0, w_mul, w_nxt, fixed, res_fix, res_p1;
    logic [XLEN:0]        sum;
    logic                 is_div_p0, sgn_a_p0, sgn_b_p0, fix_wide, fix_neg_hi, fix_neg_lo;
    logic                 vld_p1, dz_p1;
    logic                 busy_q, done_q, dz_q;
    logic [XLEN-1:0]      hi_q, lo_q;

    assign op     = md_op_e'(bus.md_op);
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign is_sgn = (op == MD_MULT) || (op == MD_DIV);
    assign a_s    = bus.A_in;
    assign b_s    = bus.B_in;
    assign neg_a  = is_sgn && (a_s < 0);
    assign neg_b  = is_sgn && (b_s < 0);
    assign mag_a  = neg_a ? -bus.A_in : bus.A_in;
    assign mag_b  = neg_b ? -bus.B_in : bus.B_in;
    // hilo_we and flush both take precedence over a same-cycle start
    assign accept = (state == IDLE) && bus.start && !bus.flush && (bus.hilo_we == 2'b00) && div_ok;

    always_comb begin
        state_nxt = state;
        fix_vld   = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (bus.flush) state_nxt = IDLE;
                else if (cnt == 5'(MD_ITER - 1)) state_nxt = FIX;
            end
            FIX: begin
                state_nxt = IDLE;
                fix_vld   = !bus.flush;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // shift-add: multiplier sits in the low half and is consumed LSB first
    assign sum   = {1'b0, w_p0[2*XLEN-1:XLEN]} + (w_p0[0] ? {1'b0, opnd_p0} : '0);
    assign w_mul = {sum, w_p0[XLEN-1:1]};

`ifdef MD_DIV_EN
    logic [XLEN-1:0] a_raw_p0, r_sh, r_sub;
    logic [2*XLEN:0] sh;
    logic            r_ge;

    // restoring step: {rem,quot} shifts left, remainder keeps its top bit in sh[2*XLEN]
    assign div_ok  = 1'b1;
    assign sh      = {w_p0, 1'b0};
    assign r_sh    = sh[2*XLEN-1:XLEN];
    assign r_ge    = sh[2*XLEN] || (r_sh >= opnd_p0);
    assign r_sub   = r_sh - opnd_p0;
    assign w_nxt   = !is_div_p0 ? w_mul :
                     r_ge       ? {r_sub, sh[XLEN-1:1], 1'b1} : sh[2*XLEN-1:0];
    assign dz_fix  = is_div_p0 && (opnd_p0 == '0);
    assign res_fix = dz_fix ? {a_raw_p0, MD_DZ_LO} : fixed;

    always_ff @(posedge clk) begin
        if (accept) a_raw_p0 <= bus.A_in;
    end
`else
    assign div_ok  = !is_div;
    assign w_nxt   = w_mul;
    assign dz_fix  = 1'b0;
    assign res_fix = fixed;
`endif

    assign fix_wide   = !is_div_p0;
    assign fix_neg_lo = sgn_a_p0 ^ sgn_b_p0;
    assign fix_neg_hi = is_div_p0 ? sgn_a_p0 : fix_neg_lo;

    md_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .mag    (w_p0),
        .wide   (fix_wide),
        .neg_hi (fix_neg_hi),
        .neg_lo (fix_neg_lo),
        .res    (fixed)
    );

    // p0: operand latch and iteration
    always_ff @(posedge clk) begin
        if (accept) begin
            opnd_p0   <= is_div ? mag_b : mag_a;
            w_p0      <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            is_div_p0 <= is_div;
            sgn_a_p0  <= neg_a;
            sgn_b_p0  <= neg_b;
        end else if (state == CALC) begin
            w_p0 <= w_nxt;
        end
        // p1: corrected result waits one cycle before the HI/LO write
        if (state == FIX) res_p1 <= res_fix;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            vld_p1 <= 1'b0;
            dz_p1  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= (state == CALC) ? cnt + 5'd1 : 5'd0;
            vld_p1 <= fix_vld;
            dz_p1  <= fix_vld && dz_fix;
            busy_q <= (state_nxt != IDLE) || fix_vld;
            done_q <= vld_p1;
            dz_q   <= vld_p1 && dz_p1;
            if (vld_p1) begin
                {hi_q, lo_q} <= res_p1;
            end else if (!busy_q) begin
                if (bus.hilo_we[1]) hi_q <= bus.A_in;
                if (bus.hilo_we[0]) lo_q <= bus.A_in;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed table of mult/div vectors plus hand-written timing sequences.
module tb_mul_div_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_hilo(input logic [1:0] we, input logic [31:0] val);
        bus.hilo_we = we;
        bus.A_in    = val;
        tick();
        bus.hilo_we = 2'b00;
    endtask

    // issue one op and count busy cycles until it drops (bounded)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bcnt);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A_in  = a;
        bus.B_in  = b;
        tick();
        bus.start = 1'b0;
        bcnt = 0;
        while (bus.busy === 1'b1 && bcnt < 60) begin
            bcnt++;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bcnt;
        int ndone;

        vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        vecs.push_back('{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0});
        vecs.push_back('{MD_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0});
`ifdef MD_DIV_EN
        vecs.push_back('{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
        vecs.push_back('{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0});
        vecs.push_back('{MD_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1});
`endif

        bus.start   = 1'b0;
        bus.md_op   = 2'b00;
        bus.A_in    = '0;
        bus.B_in    = '0;
        bus.hilo_we = 2'b00;
        bus.flush   = 1'b0;
        rst_n       = 1'b0;
        tick();
        tick();
        check("reset_hilo", {bus.HI, bus.LO}, 64'h0);
        check("reset_ctrl", {61'h0, bus.busy, bus.done, bus.div_zero}, 64'h0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bcnt);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd34);
            check($sformatf("vec%0d_done", i), {63'h0, bus.done}, 64'h1);
            check($sformatf("vec%0d_div_zero", i), {63'h0, bus.div_zero}, {63'h0, vecs[i].dz});
            check($sformatf("vec%0d_hilo", i), {bus.HI, bus.LO}, {vecs[i].hi, vecs[i].lo});
            tick();
            check($sformatf("vec%0d_done_pulse", i), {62'h0, bus.done, bus.div_zero}, 64'h0);
        end

        // mthi/mtlo with one-cycle visibility
        set_hilo(2'b01, 32'h0000_1234);
        check("mtlo", {32'h0, bus.LO}, 64'h1234);
        set_hilo(2'b10, 32'h0000_7777);
        check("mthi", {32'h0, bus.HI}, 64'h7777);

        // mthi during busy dropped, start during busy ignored
        bus.start = 1'b1; bus.md_op = MD_MULTU; bus.A_in = 32'd3; bus.B_in = 32'd5;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        set_hilo(2'b10, 32'h0000_DEAD);
        check("mthi_busy_dropped", {32'h0, bus.HI}, 64'h7777);
        repeat (2) tick();
        bus.start = 1'b1; bus.md_op = MD_MULTU; bus.A_in = 32'd2; bus.B_in = 32'd2;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.done === 1'b1) ndone++;
            tick();
        end
        check("start_busy_single_done", 64'(ndone), 64'd1);
        check("start_busy_result", {bus.HI, bus.LO}, 64'd15);

        // back-to-back: second start accepted at edge N+34
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.A_in = 32'hFFFF_FFFD; bus.B_in = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (33) tick();
        check("b2b_busy_last", {63'h0, bus.busy}, 64'h1);
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.A_in = 32'hFFFF_FFFE; bus.B_in = 32'hFFFF_FFFC;
        tick();
        bus.start = 1'b0;
        check("b2b_overlap", {62'h0, bus.done, bus.busy}, 64'h3);
        check("b2b_first_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        repeat (33) tick();
        check("b2b_second_busy", {63'h0, bus.busy}, 64'h1);
        tick();
        check("b2b_second_done", {62'h0, bus.done, bus.busy}, 64'h2);
        check("b2b_second_hilo", {bus.HI, bus.LO}, 64'h8);

        // flush mid-CALC leaves HI/LO alone and produces no done
        set_hilo(2'b10, 32'h0000_0011);
        set_hilo(2'b01, 32'h0000_0022);
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.A_in = 32'd5; bus.B_in = 32'd5;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", {63'h0, bus.busy}, 64'h0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) ndone++;
            tick();
        end
        check("flush_no_done", 64'(ndone), 64'd0);
        check("flush_hilo", {bus.HI, bus.LO}, 64'h0000_0011_0000_0022);

        // reset mid-CALC, then a fresh operation still works
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.A_in = 32'd5; bus.B_in = 32'd5;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_hilo", {bus.HI, bus.LO}, 64'h0);
        check("rst_mid_busy", {62'h0, bus.busy, bus.done}, 64'h0);
        run_op(MD_MULT, 32'd5, 32'd5, bcnt);
        check("rst_after_cycles", 64'(bcnt), 64'd34);
        check("rst_after_hilo", {bus.HI, bus.LO}, 64'd25);
        tick();

        // flush in IDLE blocks start; hilo_we beats same-cycle start
        bus.flush = 1'b1; bus.start = 1'b1; bus.md_op = MD_MULT; bus.A_in = 32'd9; bus.B_in = 32'd9;
        tick();
        bus.flush = 1'b0; bus.start = 1'b0;
        check("flush_idle_blocks_start", {63'h0, bus.busy}, 64'h0);
        bus.start = 1'b1; bus.hilo_we = 2'b01; bus.A_in = 32'h55; bus.B_in = 32'd3;
        tick();
        bus.start = 1'b0; bus.hilo_we = 2'b00;
        check("hilo_we_wins_busy", {63'h0, bus.busy}, 64'h0);
        check("hilo_we_wins_lo", {32'h0, bus.LO}, 64'h55);

`ifndef MD_DIV_EN
        // divider not built: div requests are ignored entirely
        set_hilo(2'b10, 32'h0000_0066);
        set_hilo(2'b01, 32'h0000_0099);
        bus.start = 1'b1; bus.md_op = MD_DIV; bus.A_in = 32'd100; bus.B_in = 32'd7;
        tick();
        bus.start = 1'b0;
        check("nodiv_busy0", {63'h0, bus.busy}, 64'h0);
        tick();
        tick();
        check("nodiv_busy2", {62'h0, bus.busy, bus.done}, 64'h0);
        check("nodiv_hilo", {bus.HI, bus.LO}, 64'h0000_0066_0000_0099);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
